// File: rtl/dcache_refill_unit_pkg.sv
// Shared parameters, FSM encoding and block word-slicing helper for the
// data-cache refill unit.
package dcache_refill_unit_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int BLOCK_SIZE  = 16;
  localparam int OFFSET_BITS = 4;
  localparam int BLOCK_BITS  = WORD_SIZE * BLOCK_SIZE;
  localparam int BLK_BITS    = 32 - OFFSET_BITS;

  localparam logic [OFFSET_BITS-1:0] CNT_ONE  = 4'd1;
  localparam logic [OFFSET_BITS-1:0] CNT_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  // Word 0 lives in the MSBs of a block, matching the cache layout.
  function automatic logic [WORD_SIZE-1:0] get_word(
    input logic [BLOCK_BITS-1:0]  blk,
    input logic [OFFSET_BITS-1:0] idx
  );
    get_word = blk[(BLOCK_SIZE - 1 - int'(idx)) * WORD_SIZE +: WORD_SIZE];
  endfunction

endpackage

// File: rtl/dcache_refill_unit_block_word_buffer.sv
// One cache block of storage with load-all, single-word write and a
// combinational word-indexed read.
module block_word_buffer
  import dcache_refill_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_all,
  input  logic [BLOCK_BITS-1:0]  load_data,
  input  logic                   wr_en,
  input  logic [OFFSET_BITS-1:0] wr_idx,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic [OFFSET_BITS-1:0] rd_idx,
  output logic [WORD_SIZE-1:0]   rd_data,
  output logic [BLOCK_BITS-1:0]  data
);

  logic [BLOCK_BITS-1:0] mem_r;

  // Block storage: a full load takes priority over a single-word write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r <= '0;
    end else if (load_all) begin
      mem_r <= load_data;
    end else if (wr_en) begin
      mem_r[(BLOCK_SIZE - 1 - int'(wr_idx)) * WORD_SIZE +: WORD_SIZE] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign rd_data = get_word(mem_r, rd_idx);
  assign data    = mem_r;

endmodule

// File: rtl/dcache_refill_unit.sv
// Miss handler between the data cache and word-wide memory: optional
// word-by-word victim write-back, word-by-word fill, single-cycle response.
module dcache_refill_unit
  import dcache_refill_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_wb,
  input  logic [31:0]           wb_addr,
  input  logic [BLOCK_BITS-1:0] wb_block,
  output logic                  resp_valid,
  output logic [31:0]           resp_addr,
  output logic [BLOCK_BITS-1:0] resp_block,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_SIZE-1:0]  mem_rdata
);

  state_t                 state_r;
  logic [OFFSET_BITS-1:0] cnt_r;
  logic [BLK_BITS-1:0]    req_blk_r;
  logic [BLK_BITS-1:0]    wb_blk_r;

  logic                   accept_s;
  logic                   fill_wr_s;
  logic [WORD_SIZE-1:0]   victim_word_s;
  logic [BLOCK_BITS-1:0]  fill_blk_s;
  logic [BLOCK_BITS-1:0]  victim_blk_unused_s;
  logic [WORD_SIZE-1:0]   fill_word_unused_s;
  logic                   offset_unused_s;

  assign accept_s        = (state_r == IDLE) && req_valid;
  assign fill_wr_s       = (state_r == FILL) && mem_ack;
  assign offset_unused_s = ^{req_addr[OFFSET_BITS-1:0], wb_addr[OFFSET_BITS-1:0]};

  // The victim read port looks one word ahead so mem_wdata can be registered.
  block_word_buffer u_victim (
    .clk       (clk),
    .rst       (rst),
    .load_all  (accept_s),
    .load_data (wb_block),
    .wr_en     (1'b0),
    .wr_idx    (cnt_r),
    .wr_data   (mem_rdata),
    .rd_idx    (cnt_r + CNT_ONE),
    .rd_data   (victim_word_s),
    .data      (victim_blk_unused_s)
  );

  block_word_buffer u_fill (
    .clk       (clk),
    .rst       (rst),
    .load_all  (accept_s),
    .load_data ({BLOCK_BITS{1'b0}}),
    .wr_en     (fill_wr_s),
    .wr_idx    (cnt_r),
    .wr_data   (mem_rdata),
    .rd_idx    (cnt_r),
    .rd_data   (fill_word_unused_s),
    .data      (fill_blk_s)
  );

  // Refill FSM; every port output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      req_blk_r  <= '0;
      wb_blk_r   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_block <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_blk_r <= req_addr[31:OFFSET_BITS];
            wb_blk_r  <= wb_addr[31:OFFSET_BITS];
            cnt_r     <= '0;
            req_ready <= 1'b0;
            mem_req   <= 1'b1;
            if (req_wb) begin
              state_r   <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= {wb_addr[31:OFFSET_BITS], 4'd0};
              mem_wdata <= get_word(wb_block, 4'd0);
            end else begin
              state_r  <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {req_addr[31:OFFSET_BITS], 4'd0};
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            if (cnt_r == CNT_LAST) begin
              state_r  <= FILL;
              cnt_r    <= '0;
              mem_we   <= 1'b0;
              mem_addr <= {req_blk_r, 4'd0};
            end else begin
              cnt_r     <= cnt_r + CNT_ONE;
              mem_addr  <= {wb_blk_r, cnt_r + CNT_ONE};
              mem_wdata <= victim_word_s;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (cnt_r == CNT_LAST) begin
              // Last word bypasses the buffer; it occupies the block LSBs.
              state_r    <= RESP;
              cnt_r      <= '0;
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_addr  <= {req_blk_r, 4'd0};
              resp_block <= {fill_blk_s[BLOCK_BITS-1:WORD_SIZE], mem_rdata};
            end else begin
              cnt_r    <= cnt_r + CNT_ONE;
              mem_addr <= {req_blk_r, cnt_r + CNT_ONE};
            end
          end
        end
        RESP: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= '0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Scoreboard bench for dcache_refill_unit: stimulus pushes expected memory
// transactions and responses, a negedge monitor plays memory and compares.
module tb_dcache_refill_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_wb;
  logic [31:0]  wb_addr;
  logic [511:0] wb_block;
  logic         resp_valid;
  logic [31:0]  resp_addr;
  logic [511:0] resp_block;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  dcache_refill_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wb(req_wb), .wb_addr(wb_addr), .wb_block(wb_block),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_block(resp_block),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_t;
  typedef struct { logic [31:0] addr; logic [511:0] blk; int lat; } resp_t;

  mem_t        mem_q[$];
  resp_t       resp_q[$];
  logic [31:0] mdl [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q = 1'b0;
  int ack_period = 1;
  bit idle_ack = 1'b0;
  int acc_cyc = 0;
  int last_acc_cyc = 0;
  int last_resp_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wword(input logic [511:0] blk, input int i);
    return blk[(15 - i) * 32 +: 32];
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mdl.exists(a)) return mdl[a];
    return a ^ PAT;
  endfunction

  // Memory model and scoreboard monitor, both at the falling edge.
  initial begin
    bit busy = 1'b0;
    int stall = 0;
    bit ack;
    mem_t e;
    resp_t r;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_req_ready", {511'd0, req_ready}, 512'd1);
        chk("rst_mem_req", {511'd0, mem_req}, 512'd0);
        chk("rst_mem_we", {511'd0, mem_we}, 512'd0);
        chk("rst_resp_valid", {511'd0, resp_valid}, 512'd0);
        chk("rst_mem_addr", {480'd0, mem_addr}, 512'd0);
        chk("rst_mem_wdata", {480'd0, mem_wdata}, 512'd0);
        chk("rst_resp_addr", {480'd0, resp_addr}, 512'd0);
        chk("rst_resp_block", resp_block, 512'd0);
        busy = 1'b0;
        stall = 0;
        mem_q.delete();
        resp_q.delete();
        mem_ack = 1'b0;
      end else begin
        chk("req_ready", {511'd0, req_ready}, {511'd0, !busy});
        ack = 1'b0;
        if (mem_req) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_access: actual addr %0h we %0b required none", mem_addr, mem_we);
          end else begin
            e = mem_q[0];
            chk("mem_we", {511'd0, mem_we}, {511'd0, e.we});
            chk("mem_addr", {480'd0, mem_addr}, {480'd0, e.addr});
            if (e.we) chk("mem_wdata", {480'd0, mem_wdata}, {480'd0, e.data});
          end
          if (!rst && stall == ack_period - 1) begin
            ack = 1'b1;
            stall = 0;
          end else begin
            stall++;
          end
          if (ack) begin
            if (mem_we) mdl[mem_addr] = mem_wdata;
            mem_rdata = mem_we ? 32'hDEAD_BEEF : mem_read(mem_addr);
            if (mem_q.size() != 0) void'(mem_q.pop_front());
          end else begin
            mem_rdata = 32'hDEAD_BEEF;
          end
        end else begin
          stall = 0;
          ack = idle_ack && !rst;
          mem_rdata = 32'hFFFF_FFFF;
        end
        mem_ack = ack;
        if (resp_valid) begin
          if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: actual resp_addr %0h required none", resp_addr);
          end else begin
            r = resp_q.pop_front();
            chk("resp_addr", {480'd0, resp_addr}, {480'd0, r.addr});
            chk("resp_block", resp_block, r.blk);
            chk("resp_latency", 512'(cyc - acc_cyc), 512'(r.lat));
          end
          last_resp_cyc = cyc;
          busy = 1'b0;
        end
        if (req_valid && req_ready) begin
          busy = 1'b1;
          acc_cyc = cyc;
          last_acc_cyc = cyc;
        end
      end
    end
  end

  // Push expectations for one miss, then present it until accepted.
  task automatic issue(input logic [31:0] ra, input logic rwb, input logic [31:0] wa,
                       input logic [511:0] wblk, input int lat, input bit hold);
    logic [31:0]  a;
    logic [31:0]  d;
    logic [511:0] exp_blk;
    bit rdy;
    int n;
    exp_blk = '0;
    if (rwb) begin
      for (int i = 0; i < 16; i++) begin
        a = {wa[31:4], 4'(i)};
        mem_q.push_back('{we: 1'b1, addr: a, data: wword(wblk, i)});
      end
    end
    for (int i = 0; i < 16; i++) begin
      a = {ra[31:4], 4'(i)};
      d = (rwb && wa[31:4] == ra[31:4]) ? wword(wblk, i) : mem_read(a);
      exp_blk[(15 - i) * 32 +: 32] = d;
      mem_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
    end
    resp_q.push_back('{addr: {ra[31:4], 4'd0}, blk: exp_blk, lat: lat});
    req_valid = 1'b1;
    req_addr  = ra;
    req_wb    = rwb;
    wb_addr   = wa;
    wb_block  = wblk;
    n = 0;
    do begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 2000);
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL accept_timeout: actual not accepted required accepted");
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL done_timeout: actual %0d pending required 0", resp_q.size() + mem_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] blk1;
    logic [511:0] blk2;
    logic [511:0] blk3;
    logic [511:0] blk4;
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wb    = 1'b0;
    wb_addr   = 32'h0;
    wb_block  = '0;
    for (int i = 0; i < 16; i++) begin
      blk1[(15 - i) * 32 +: 32] = 32'(i + 1);
      blk2[(15 - i) * 32 +: 32] = 32'h1111_0000 + 32'(i);
      blk3[(15 - i) * 32 +: 32] = 32'hC000_0000 + 32'(i);
      blk4[(15 - i) * 32 +: 32] = 32'hDEAD_0000 + 32'(i) * 32'h111;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clean fill, memory acks every cycle.
    issue(32'h0000_1234, 1'b0, 32'h0, '0, 17, 1'b0);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    chk("resp_addr_hold", {480'd0, resp_addr}, {480'd0, 32'h0000_1230});
    chk("resp_word0_hold", {480'd0, resp_block[511:480]}, {480'd0, 32'hA5A5_1230});

    // Dirty write-back then fill.
    issue(32'h0000_4010, 1'b1, 32'h0000_8000, blk1, 33, 1'b0);
    wait_done();

    // Stalling memory plus spurious acks while idle.
    ack_period = 3;
    idle_ack = 1'b1;
    issue(32'h0000_2000, 1'b0, 32'h0, '0, 49, 1'b0);
    wait_done();
    issue(32'h0000_2100, 1'b1, 32'h0000_2200, blk2, 97, 1'b0);
    wait_done();
    ack_period = 1;
    idle_ack = 1'b0;

    // Back-pressure: req_valid held across two requests.
    issue(32'h0000_3000, 1'b0, 32'h0, '0, 17, 1'b1);
    issue(32'h0000_3100, 1'b0, 32'h0, '0, 17, 1'b0);
    chk("bp_second_accept", 512'(last_acc_cyc), 512'(last_resp_cyc + 1));
    wait_done();

    // Reset at word 5 of a write-back, then restart from word 0.
    issue(32'h0000_5000, 1'b1, 32'h0000_9000, blk3, 33, 1'b0);
    n = 0;
    while (mem_addr !== 32'h0000_9005 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reached_word5", {480'd0, mem_addr}, {480'd0, 32'h0000_9005});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(32'h0000_5000, 1'b1, 32'h0000_9000, blk3, 33, 1'b0);
    wait_done();

    // Same block written back and then refilled.
    issue(32'h0000_7005, 1'b1, 32'h0000_7000, blk4, 33, 1'b0);
    wait_done();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_refill_unit.md
Name: dcache_refill_unit

Overview:
- Sits directly downstream of the data cache, between the cache and the word-wide data memory.
- On a cache miss it accepts one request. It optionally writes back the dirty victim block word by word, then reads the new 16-word block word by word.
- It returns the assembled block to the cache in a single response pulse.
- The cache therefore no longer talks to memory with whole-block, zero-latency transfers.

Parameters:
- WORD_SIZE, 32, bits per word; addresses are word addresses.
- BLOCK_SIZE, 16, words per block; the word offset is addr[3:0].
- OFFSET_BITS, 4, log2(BLOCK_SIZE).

Ports:
- clk  in  1  clock; every flop updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  cache miss request.
- req_ready  out  1  unit is idle and can accept a request.
- req_addr  in  32  miss address; only bits [31:4] are used.
- req_wb  in  1  the victim is dirty and must be written back first.
- wb_addr  in  32  victim address; only bits [31:4] are used.
- wb_block  in  WORD_SIZE*BLOCK_SIZE  victim block data.
- resp_valid  out  1  one-cycle pulse: refill complete.
- resp_addr  out  32  {req block address, 4'b0}.
- resp_block  out  WORD_SIZE*BLOCK_SIZE  refilled block.
- mem_req  out  1  word access request to memory.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  32  word address.
- mem_wdata  out  WORD_SIZE  write data.
- mem_ack  in  1  memory completes the current word access this cycle.
- mem_rdata  in  WORD_SIZE  read data; valid when mem_ack=1 and mem_we=0.

Behaviour:
- Word i of a block occupies bits [(BLOCK_SIZE-1-i)*WORD_SIZE +: WORD_SIZE], so word 0 sits in the MSBs. This matches the cache's block layout.
- Reset values:
  - State is IDLE and the word counter is 0.
  - req_ready=1 on the cycle after reset.
  - resp_valid, mem_req and mem_we are 0.
  - mem_addr, mem_wdata, resp_addr and resp_block are 0.
- Reset mid-operation: the transfer is abandoned at the next edge, including a partial write-back, and no response is produced. mem_req drops the cycle after rst is sampled.
- FSM states: IDLE, WB, FILL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch req_addr[31:4], wb_addr[31:4], wb_block and req_wb, and clear the counter.
  - Go to WB if req_wb=1, otherwise go to FILL.
- WB:
  - Drive mem_req=1, mem_we=1, mem_addr={wb_blk, cnt}, mem_wdata=word cnt of the latched wb_block.
  - Hold all of these stable until mem_ack.
  - On ack, cnt+1. On the ack with cnt=15, go to FILL with cnt=0.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr={req_blk, cnt}.
  - On ack, store mem_rdata into word cnt of the block buffer, then cnt+1.
  - On the ack with cnt=15, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_block = buffer and resp_addr={req_blk, 4'b0}.
  - Then go to IDLE. There is no backpressure on resp; the cache must consume it in that cycle.
  - resp_block and resp_addr hold their values after the pulse until the next RESP.
- req_ready=0 in every state except IDLE. A req_valid seen outside IDLE is ignored and not queued.
- Latency with a memory that acks every cycle:
  - FILL only: 16 cycles, then resp_valid on the 17th cycle after acceptance.
  - With write-back: resp_valid on the 33rd cycle.
- mem_ack while mem_req=0 is ignored.
- The counter wraps 15 to 0 only on the state change; it never overflows into the address.
- If wb_addr[31:4] equals req_addr[31:4], the unit still runs the write-back and then the fill, in that order. The fill returns the just-written data.
- Consecutive requests: a request may be accepted in the IDLE cycle right after RESP. The minimum spacing is one idle cycle.

Decomposition:
- Shared header (the parameters.v include) holds:
  - WORD_SIZE, BLOCK_SIZE, OFFSET_BITS.
  - The FSM state encodings (IDLE=2'd0, WB=2'd1, FILL=2'd2, RESP=2'd3).
- One natural sub-module: block_word_buffer.
  - A WORD_SIZE*BLOCK_SIZE register.
  - Synchronous word-indexed write (load-all, write-word) and a combinational word-indexed read.
  - Used for both the latched victim and the fill buffer.

Test Plan:
- Clean fill:
  - Stimulus: req_addr=32'h0000_1234, req_wb=0, and a memory that acks every cycle with rdata=addr^32'hA5A5_0000.
  - Required: reads at 0x1230..0x123F in order, then resp_valid at cycle 17 with word 0 = 32'hA5A5_1230, resp_addr=0x1230.
- Dirty write-back then fill:
  - Stimulus: wb_addr=0x8000, wb_block word i = i+1, req_addr=0x4010.
  - Required: 16 writes at 0x8000..0x800F with data 1..16, then 16 reads at 0x4010..0x401F, then resp_valid at cycle 33.
- Stalling memory:
  - Stimulus: ack only every 3rd cycle.
  - Required: mem_addr, mem_we and mem_wdata stay stable between acks, and the total fill time is 48 cycles plus the response cycle.
- Back-pressure:
  - Stimulus: req_valid held high throughout.
  - Required: req_ready=0 during WB, FILL and RESP. The second request is accepted only in the IDLE cycle after resp_valid.
- Reset mid write-back:
  - Stimulus: assert rst for one cycle at word 5 of the write-back.
  - Required: mem_req=0 the next cycle, no resp_valid, req_ready=1, and a new request then starts at word 0.
- Same-block write-back:
  - Stimulus: wb_addr[31:4] equal to req_addr[31:4], with memory as a behavioural array.
  - Required: resp_block equals wb_block.
